// File: rtl/lmfe_pixel_feeder_if.sv
// lmfe_pixel_feeder_if
// Handshake bundle between the host pixel source, the pixel feeder and the
// median filter engine.
//   Host side   : s_valid, s_ready, s_data[7:0], s_sof
//   Engine side : busy, in_en, Din[7:0]
// The feeder uses the slave modport; the surrounding host/engine
// environment uses the master modport.
interface lmfe_pixel_feeder_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_sof;
  logic       busy;
  logic       in_en;
  logic [7:0] Din;

  modport master (
    output s_valid, s_data, s_sof, busy,
    input  s_ready, in_en, Din
  );

  modport slave (
    input  s_valid, s_data, s_sof, busy,
    output s_ready, in_en, Din
  );
endinterface

// File: rtl/lmfe_pixel_feeder.sv
// lmfe_pixel_feeder
// Input stage of the local median filter engine. Host pixels arrive over a
// valid/ready handshake, are buffered in a small circular FIFO of {sof, data}
// entries and are handed to the engine whenever it is not busy. The block
// also tracks the pixel index inside the frame, pulses frame_done after the
// last pixel of a frame and raises a sticky error when a start-of-frame
// marker shows up in the middle of a frame.
// Ports:
//   clk        : single rising-edge clock
//   reset      : asynchronous, active-low reset
//   bus        : slave side of lmfe_pixel_feeder_if (host and engine handshakes)
//   frame_done : one-cycle pulse after the last pixel of a frame is transferred
//   pix_cnt    : index of the next pixel to transfer within the frame
//   fifo_level : current FIFO occupancy
//   err_sof    : sticky start-of-frame misalignment flag
module lmfe_pixel_feeder #(
  parameter int FIFO_DEPTH = 16,
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128
) (
  input  logic                               clk,
  input  logic                               reset,
  lmfe_pixel_feeder_if.slave                 bus,
  output logic                               frame_done,
  output logic [$clog2(IMG_W*IMG_H)-1:0]     pix_cnt,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic                               err_sof
);

  localparam int PIX_TOTAL = IMG_W * IMG_H;
  localparam int CNT_W     = $clog2(PIX_TOTAL);
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [8:0]       head;
  logic             not_empty;
  logic             push;
  logic             pop;

  assign head      = mem[rd_ptr];
  assign not_empty = (fifo_level != '0);

  // s_ready depends only on the registered level, so a full FIFO refuses a
  // host pixel even in a cycle where the engine is draining one.
  assign bus.s_ready = (fifo_level < FULL_LVL);
  assign bus.in_en   = not_empty & ~bus.busy;
  assign bus.Din     = not_empty ? head[7:0] : 8'h00;

  assign push = bus.s_valid & bus.s_ready;
  assign pop  = bus.in_en;

  // Storage carries no reset: entries are only ever read behind the level
  // counter, which is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.s_sof, bus.s_data};
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // A misplaced sof restarts the frame at this pixel (so the next index is 1)
  // and suppresses frame_done for the truncated frame; a missing sof at
  // index 0 is tolerated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt    <= '0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pop) begin
        if (head[8] && (pix_cnt != '0)) begin
          err_sof <= 1'b1;
          pix_cnt <= CNT_ONE;
        end else if (pix_cnt == LAST_PIX) begin
          pix_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lmfe_pixel_feeder.sv
// tb_lmfe_pixel_feeder
// Directed bench for lmfe_pixel_feeder with a 4x2 frame and a 4-entry FIFO.
// A negedge monitor logs every engine transfer, host accept and frame_done
// pulse; directed sequences then compare those logs and the status outputs
// against hand-computed values.
module tb_lmfe_pixel_feeder;

  localparam int FIFO_DEPTH = 4;
  localparam int IMG_W      = 4;
  localparam int IMG_H      = 2;

  logic       clk;
  logic       reset;
  logic       frame_done;
  logic [2:0] pix_cnt;
  logic [2:0] fifo_level;
  logic       err_sof;

  lmfe_pixel_feeder_if bus ();

  lmfe_pixel_feeder #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .frame_done(frame_done),
    .pix_cnt   (pix_cnt),
    .fifo_level(fifo_level),
    .err_sof   (err_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor logs: transferred data, cycle of each transfer/accept/pulse.
  logic [7:0] rec_q[$];
  int         en_cyc[$];
  int         push_cyc[$];
  int         done_cyc[$];
  int         busy_viol = 0;
  int         cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (bus.in_en) begin
        rec_q.push_back(bus.Din);
        en_cyc.push_back(cyc);
      end
      if (bus.in_en && bus.busy) busy_viol++;
      if (bus.s_valid && bus.s_ready) push_cyc.push_back(cyc);
      if (frame_done) done_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offers one host pixel and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [7:0] d, input logic sof);
    int guard;
    guard = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_sof   = sof;
    @(negedge clk);
    while (!bus.s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) checkOutput("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_en"},      bus.in_en,  32'd0);
    checkOutput({tag, "_din"},        bus.Din,    32'd0);
    checkOutput({tag, "_frame_done"}, frame_done, 32'd0);
    checkOutput({tag, "_pix_cnt"},    pix_cnt,    32'd0);
    checkOutput({tag, "_level"},      fifo_level, 32'd0);
    checkOutput({tag, "_err_sof"},    err_sof,    32'd0);
    checkOutput({tag, "_s_ready"},    bus.s_ready, 32'd1);
  endtask

  initial begin
    int rb, eb, pb, db, vb;

    reset       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_sof   = 1'b0;
    bus.busy    = 1'b0;
    #12;
    checkResetValues("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic stream: 8 back-to-back pixels, engine always ready.
    rb = rec_q.size(); eb = en_cyc.size(); pb = push_cyc.size(); db = done_cyc.size();
    for (int i = 0; i < 8; i++) applyStimulus(8'h10 + 8'(i), i == 0);
    waitCycles(4);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("basic_din%0d", i), rec_q[rb + i], 32'h10 + i);
    checkOutput("basic_xfer_count", rec_q.size() - rb, 32'd8);
    checkOutput("basic_latency", en_cyc[eb], push_cyc[pb] + 1);
    checkOutput("basic_consecutive", en_cyc[eb + 7], en_cyc[eb] + 7);
    checkOutput("basic_done_count", done_cyc.size() - db, 32'd1);
    checkOutput("basic_done_cycle", done_cyc[db], en_cyc[eb + 7] + 1);
    checkOutput("basic_pix_cnt_end", pix_cnt, 32'd0);
    checkOutput("basic_err_sof", err_sof, 32'd0);

    // Full FIFO: engine busy, 4 accepts fill it, the rest wait for a drain.
    doReset();
    rb = rec_q.size();
    bus.busy = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i), i == 0);
    checkOutput("full_level", fifo_level, 32'd4);
    checkOutput("full_s_ready", bus.s_ready, 32'd0);
    checkOutput("full_in_en", bus.in_en, 32'd0);
    checkOutput("full_head", bus.Din, 32'h10);
    waitCycles(2);
    checkOutput("full_level_hold", fifo_level, 32'd4);
    checkOutput("full_head_hold", bus.Din, 32'h10);
    bus.busy = 1'b0;
    #1;
    checkOutput("full_pop_in_en", bus.in_en, 32'd1);
    checkOutput("full_pop_s_ready", bus.s_ready, 32'd0);
    applyStimulus(8'h14, 1'b0);
    applyStimulus(8'h15, 1'b0);
    waitCycles(6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("full_din%0d", i), rec_q[rb + i], 32'h10 + i);
    checkOutput("full_xfer_count", rec_q.size() - rb, 32'd6);
    checkOutput("full_drained", fifo_level, 32'd0);

    // Busy toggling every cycle during an 8-pixel frame.
    doReset();
    rb = rec_q.size(); db = done_cyc.size(); vb = busy_viol;
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(8'h20 + 8'(i), i == 0);
      end
      begin
        for (int k = 0; k < 60 && rec_q.size() < rb + 8; k++) begin
          @(posedge clk);
          #1;
          bus.busy = ~bus.busy;
        end
        bus.busy = 1'b0;
      end
    join
    waitCycles(4);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("toggle_din%0d", i), rec_q[rb + i], 32'h20 + i);
    checkOutput("toggle_xfer_count", rec_q.size() - rb, 32'd8);
    checkOutput("toggle_busy_violations", busy_viol - vb, 32'd0);
    checkOutput("toggle_done_count", done_cyc.size() - db, 32'd1);

    // Simultaneous push/pop at level 2 across several pointer wraps.
    doReset();
    rb = rec_q.size(); db = done_cyc.size();
    bus.busy = 1'b1;
    applyStimulus(8'h30, 1'b1);
    applyStimulus(8'h31, 1'b0);
    checkOutput("pp_level_start", fifo_level, 32'd2);
    bus.busy = 1'b0;
    for (int i = 2; i < 12; i++) begin
      applyStimulus(8'h30 + 8'(i), 1'b0);
      checkOutput($sformatf("pp_level%0d", i), fifo_level, 32'd2);
    end
    waitCycles(4);
    for (int i = 0; i < 12; i++)
      checkOutput($sformatf("pp_din%0d", i), rec_q[rb + i], 32'h30 + i);
    checkOutput("pp_pix_cnt", pix_cnt, 32'd4);
    checkOutput("pp_done_count", done_cyc.size() - db, 32'd1);

    // SOF error: sof on the 3rd pixel restarts the frame count.
    doReset();
    db = done_cyc.size();
    applyStimulus(8'h40, 1'b1);
    waitCycles(1);
    checkOutput("sof_cnt_after_p0", pix_cnt, 32'd1);
    applyStimulus(8'h41, 1'b0);
    waitCycles(1);
    checkOutput("sof_cnt_after_p1", pix_cnt, 32'd2);
    checkOutput("sof_no_err_yet", err_sof, 32'd0);
    applyStimulus(8'h42, 1'b1);
    waitCycles(1);
    checkOutput("sof_cnt_restart", pix_cnt, 32'd1);
    checkOutput("sof_err_set", err_sof, 32'd1);
    for (int i = 3; i < 9; i++) applyStimulus(8'h40 + 8'(i), 1'b0);
    waitCycles(1);
    checkOutput("sof_cnt_before_last", pix_cnt, 32'd7);
    checkOutput("sof_no_early_done", done_cyc.size() - db, 32'd0);
    applyStimulus(8'h49, 1'b0);
    waitCycles(1);
    checkOutput("sof_done_pulse", frame_done, 32'd1);
    checkOutput("sof_cnt_wrap", pix_cnt, 32'd0);
    waitCycles(1);
    checkOutput("sof_done_one_cycle", frame_done, 32'd0);
    checkOutput("sof_err_sticky", err_sof, 32'd1);

    // Mid-frame reset with 2 pixels buffered behind a busy engine.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(8'h50 + 8'(i), i == 0);
    waitCycles(1);
    checkOutput("mid_cnt_before", pix_cnt, 32'd5);
    bus.busy = 1'b1;
    applyStimulus(8'h55, 1'b0);
    applyStimulus(8'h56, 1'b0);
    checkOutput("mid_level_before", fifo_level, 32'd2);
    reset = 1'b0;
    #1;
    checkResetValues("mid_reset");
    @(posedge clk);
    #1;
    reset    = 1'b1;
    bus.busy = 1'b0;
    rb = rec_q.size(); db = done_cyc.size();
    for (int i = 0; i < 8; i++) applyStimulus(8'h60 + 8'(i), i == 0);
    waitCycles(4);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("mid_din%0d", i), rec_q[rb + i], 32'h60 + i);
    checkOutput("mid_xfer_count", rec_q.size() - rb, 32'd8);
    checkOutput("mid_done_count", done_cyc.size() - db, 32'd1);
    checkOutput("mid_pix_cnt_end", pix_cnt, 32'd0);
    checkOutput("mid_err_sof", err_sof, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
